imem_responder: RTL
===================

# imem_responder

Instruction-memory responder for the 5-stage RISC-V pipeline core: the memory-side end of the core's `imem_A` / `imem_read` / `imem_ready` / `imem_RD` fetch interface. It holds a word-addressed instruction store and answers each fetch request after a configurable number of wait states, which exercises the core's `StallF` path. A side loader port lets boot code or the bench fill the store. Out-of-range and misaligned fetches return a NOP and flag an error.

## Interface
- `DEPTH_WORDS`, 1024: store size in 32-bit words; power of two, 16..65536.
- `WAIT_STATES`, 2: extra cycles between request capture and data return; 0..15.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `imem_A`  in  32: byte address of the fetch; held stable by the core while `imem_read` is high.
- `imem_read`  in  1: fetch request level.
- `imem_ready`  out  1: one-cycle pulse; `imem_RD` is valid in this cycle.
- `imem_RD`  out  32: fetched instruction word.
- `imem_err`  out  1: one-cycle pulse coincident with `imem_ready` when the fetch was misaligned or out of range.
- `ld_we`  in  1: loader write enable.
- `ld_addr`  in  clog2(DEPTH_WORDS): loader word index.
- `ld_data`  in  32: loader write data.

## Operation
- FSM states:
  - **IDLE**: if `imem_read`=1, capture `imem_A` into `req_addr`. If `WAIT_STATES`=0, go to RESP; otherwise load `cnt`=`WAIT_STATES`-1 and go to WAIT.
  - **WAIT**: decrement `cnt`. When `cnt`=0, go to RESP.
  - **RESP**: drive `imem_ready`=1 for exactly one cycle, then return to IDLE unconditionally.
- Data load: the store read is performed on the edge that enters RESP. `imem_RD` is registered and holds its value until the next RESP.
- Abort, WAIT or during the entry edge:
  - If `imem_read`=0, return to IDLE with no response.
  - If `imem_A` ≠ `req_addr` while `imem_read`=1 (core redirect), re-capture the new address and restart the count from `WAIT_STATES`. No response is issued for the old address.
- Errors:
  - `req_addr[1:0]`≠0, or word index `req_addr[31:2]` ≥ `DEPTH_WORDS`: respond normally in timing, with `imem_RD`=32'h0000_0013 (addi x0,x0,0) and `imem_err`=1.
  - No store access occurs for an error fetch.
- Loader:
  - `ld_we` writes `ld_data` at `ld_addr` on the edge; it is accepted in any FSM state.
  - A same-edge write and read of the same word returns the OLD data (read-before-write).
- `imem_ready` is never asserted while `imem_read`=0 in the preceding cycle, except for the RESP of a request that completed its count.
- Reset:
  - State IDLE, `cnt`=0, `req_addr`=0.
  - `imem_ready`=0, `imem_RD`=32'h0, `imem_err`=0.
  - Store contents are not reset.

## Timing
- Request sampled at edge k → `imem_ready` high in the cycle after edge k+`WAIT_STATES`. Latency is `WAIT_STATES`+1 cycles.
- Throughput: one fetch per `WAIT_STATES`+2 cycles. The cycle after RESP is IDLE and samples the core's next address.
- Reset asserted mid-request: outputs clear immediately (asynchronously) and the pending fetch is dropped. After deassertion the first request is taken in IDLE.
- Redirect on the last WAIT cycle: the restart wins and no stale `imem_ready` is issued.
- `cnt` width is 4 bits. Decrement never wraps because the FSM leaves WAIT at 0.

## Structure
- Package `imem_pkg`:
  - state enum `imem_state_t` {IDLE, WAIT, RESP};
  - `NOP_INSTR`=32'h0000_0013;
  - `MAX_WAIT_STATES`=15.
- Sub-module `imem_array_1r1w`: synchronous-read, synchronous-write word array with a read-before-write same-address rule. It is parameterized by `DEPTH_WORDS` and takes an optional init file for simulation.
- The FSM, counter, address compare and error checks stay in `imem_responder`.

## Test plan
- WAIT_STATES=2: preload word 4 = 32'h00500093. Hold `imem_read`=1, `imem_A`=0x10 from edge 0 → `imem_ready`=1 only in the cycle after edge 2, with `imem_RD`=0x00500093 and `imem_err`=0.
- WAIT_STATES=0, continuous `imem_read` over addresses 0x0, 0x4, 0x8 → `imem_ready` in alternate cycles, with data matching preloaded words 0, 1, 2.
- Redirect: request 0x20, then change `imem_A` to 0x40 after one WAIT cycle → a single `imem_ready` occurs 3 cycles after the change, carrying word 16. No pulse occurs for 0x20.
- Error fetches:
  - `imem_A`=0x6 (misaligned) → `imem_RD`=0x00000013 with `imem_err`=1.
  - DEPTH_WORDS=1024, `imem_A`=0x1000 → same NOP response with `imem_err`=1.
- Loader collision: `ld_we` to word 3 (value 0xDEADBEEF) on the edge entering RESP for 0xC → old value returned. A re-fetch of 0xC returns 0xDEADBEEF.
- Reset pulled low during WAIT → `imem_ready`, `imem_RD` and `imem_err` are 0 at once. After release, a request to 0x0 completes with normal latency.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_t;

  // addi x0, x0, 0 -- returned for misaligned or out-of-range fetches
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned MAX_WAIT_STATES = 15;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/imem_responder_if.sv
// Core fetch bus: the core is the master, the instruction memory the slave.
interface imem_responder_if;

  logic [31:0] imem_A;
  logic        imem_read;
  logic        imem_ready;
  logic [31:0] imem_RD;
  logic        imem_err;

  modport master (
    output imem_A,
    output imem_read,
    input  imem_ready,
    input  imem_RD,
    input  imem_err
  );

  modport slave (
    input  imem_A,
    input  imem_read,
    output imem_ready,
    output imem_RD,
    output imem_err
  );

endinterface

// File: rtl/imem_array_1r1w.sv
// Word array with one synchronous read port and one synchronous write port.
// A read and a write to the same word on the same edge return the old word.
module imem_array_1r1w #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  // Read data only changes when a read is requested; otherwise it holds.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // Read-data register; cleared by reset so the bus shows zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  // Store write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: answers each core fetch after WAIT_STATES
// extra cycles, with redirect/abort handling and a side loader port.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  imem_responder_if.slave                imem,
  input  logic                           ld_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [31:0]                    ld_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_RELOAD =
    (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

  imem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic             err_q, err_d;

  logic             fetch_err;
  logic             rd_en;
  logic [AW-1:0]    rd_idx;
  logic [31:0]      rd_data;

  // Next-state, counter and address capture; the store read and error flag
  // are evaluated on the address that will be held after the edge entering RESP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_addr_d = req_addr_q;
    err_d      = err_q;
    fetch_err  = 1'b0;
    rd_en      = 1'b0;
    rd_idx     = '0;

    unique case (state_q)
      IDLE: begin
        if (imem.imem_read) begin
          req_addr_d = imem.imem_A;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            cnt_d   = CNT_RELOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!imem.imem_read) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (imem.imem_A != req_addr_q) begin
          // Redirect restarts the full latency, even on the last wait cycle.
          req_addr_d = imem.imem_A;
          cnt_d      = CNT_RELOAD;
        end else if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    fetch_err = (|req_addr_d[1:0]) | (|req_addr_d[31:AW+2]);
    rd_idx    = req_addr_d[AW+1:2];
    if (state_d == RESP) begin
      err_d = fetch_err;
      rd_en = ~fetch_err;
    end
  end

  // State, counter, captured address and error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_addr_q <= req_addr_d;
      err_q      <= err_d;
    end
  end

  imem_array_1r1w #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ld_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .re    (rd_en),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  // Both the store word and the error flag hold between responses, so the
  // returned word stays stable until the next RESP.
  assign imem.imem_ready = (state_q == RESP);
  assign imem.imem_err   = (state_q == RESP) & err_q;
  assign imem.imem_RD    = err_q ? NOP_INSTR : rd_data;

endmodule
